sort1_s_axil_regs: RTL and testbench

AXI4-Lite slave (responder) register bank for the sort1 IP. It terminates the S00_AXI port driven by the block-design master. It exposes NUM_REGS 32-bit read/write registers to the sort core and signals each committed write to it. It is the target of sequential AXI4LITE write/read bursts at offsets 0x0, 0x4, 0x8, 0xC.

---
 rtl/sort1_axil_pkg.sv | 14 +
 rtl/sort1_axil_hold_buf.sv | 35 +++
 rtl/sort1_s_axil_regs.sv | 152 +++++++++++++++
 tb/tb_sort1_s_axil_regs.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort1_axil_pkg.sv
// Shared AXI4-Lite response codes, register offsets and types for the sort1 register bank.
package sort1_axil_pkg;

    typedef logic [1:0] axil_resp_t;

    localparam axil_resp_t RESP_OKAY   = 2'b00;
    localparam axil_resp_t RESP_SLVERR = 2'b10;

    localparam logic [3:0] REG0_OFF = 4'h0;
    localparam logic [3:0] REG1_OFF = 4'h4;
    localparam logic [3:0] REG2_OFF = 4'h8;
    localparam logic [3:0] REG3_OFF = 4'hC;

endpackage

// File: rtl/sort1_axil_hold_buf.sv
// One-entry valid/ready holding register; fills on handshake, empties on clear.
module sort1_axil_hold_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             clear_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready_o = !full_q && enable_i;
    assign full_o     = full_q;
    assign data_o     = data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            full_q <= 1'b1;
            data_q <= in_data_i;
        end
    end

endmodule

// File: rtl/sort1_s_axil_regs.sv
// AXI4-Lite slave register bank for the sort1 core: NUM_REGS r/w registers plus commit strobes.
module sort1_s_axil_regs
    import sort1_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned NUM_REGS           = 4
) (
    input  logic                                 ACLK,
    input  logic                                 ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                           S_AXI_AWPROT,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                           S_AXI_ARPROT,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_q,
    output logic [NUM_REGS-1:0]                  wr_pulse
);

    localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned IDX_W = AW - 2;

    logic [1:0]                   rst_sync_q;
    logic                         rst_sync;
    logic [NUM_REGS-1:0][DW-1:0]  regs_q;
    logic [NUM_REGS-1:0]          wr_pulse_q;
    logic                         bvalid_q, rvalid_q;
    axil_resp_t                   bresp_q, rresp_q;
    logic [DW-1:0]                rdata_q;

    logic                         aw_full, w_full, commit, buf_enable;
    logic [AW-1:0]                aw_addr;
    logic [DW-1:0]                w_data;
    logic [SW-1:0]                w_strb;
    logic [IDX_W-1:0]             wr_idx, rd_idx;
    logic                         wr_in_range, rd_in_range, ar_hs;
    logic [DW-1:0]                rd_data;
    logic                         unused_bits;

    // READY stays low until reset deassertion has passed through both sync flops.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_sync   = rst_sync_q[1];
    assign buf_enable = !bvalid_q && rst_sync;

    sort1_axil_hold_buf #(.WIDTH(AW)) u_aw_buf (
        .clk_i      (ACLK),
        .rst_ni     (ARESETN),
        .enable_i   (buf_enable),
        .in_valid_i (S_AXI_AWVALID),
        .in_ready_o (S_AXI_AWREADY),
        .in_data_i  (S_AXI_AWADDR),
        .clear_i    (commit),
        .full_o     (aw_full),
        .data_o     (aw_addr)
    );

    sort1_axil_hold_buf #(.WIDTH(DW + SW)) u_w_buf (
        .clk_i      (ACLK),
        .rst_ni     (ARESETN),
        .enable_i   (buf_enable),
        .in_valid_i (S_AXI_WVALID),
        .in_ready_o (S_AXI_WREADY),
        .in_data_i  ({S_AXI_WSTRB, S_AXI_WDATA}),
        .clear_i    (commit),
        .full_o     (w_full),
        .data_o     ({w_strb, w_data})
    );

    assign commit      = aw_full && w_full && !bvalid_q;
    assign wr_idx      = aw_addr[AW-1:2];
    assign rd_idx      = S_AXI_ARADDR[AW-1:2];
    assign wr_in_range = 32'(wr_idx) < NUM_REGS;
    assign rd_in_range = 32'(rd_idx) < NUM_REGS;
    assign ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(rd_idx) == i) rd_data = regs_q[i];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            regs_q     <= '0;
            wr_pulse_q <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                wr_pulse_q[i] <= commit && (32'(wr_idx) == i);
                if (commit && (32'(wr_idx) == i)) begin
                    for (int unsigned b = 0; b < SW; b++) begin
                        if (w_strb[b]) regs_q[i][8*b +: 8] <= w_data[8*b +: 8];
                    end
                end
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Captures regs_q before any same-edge commit lands, so reads see the pre-write value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign S_AXI_ARREADY = !rvalid_q && rst_sync;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign reg_q         = regs_q;
    assign wr_pulse      = wr_pulse_q;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_sort1_s_axil_regs.sv
// Scoreboard bench for sort1_s_axil_regs: a 4-register and a 2-register instance share one bus.
module tb_sort1_s_axil_regs;
    import sort1_axil_pkg::*;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [127:0] regq;
    logic [3:0]  wr_pulse;

    logic        awready2, wready2, bvalid2, arready2, rvalid2;
    logic [1:0]  bresp2, rresp2;
    logic [31:0] rdata2;
    logic [63:0] regq2;
    logic [1:0]  wr_pulse2;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [1:0] resp;
        logic [1:0] resp2;
        logic [3:0] pulse;
        logic [1:0] pulse2;
    } b_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] data2;
        logic [1:0]  resp2;
    } r_exp_t;

    b_exp_t b_q[$];
    r_exp_t r_q[$];
    logic [31:0] m1[4];
    logic [31:0] m2[2];

    always #5 clk = ~clk;

    sort1_s_axil_regs dut (
        .ACLK(clk), .ARESETN(aresetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready), .reg_q(regq), .wr_pulse(wr_pulse)
    );

    sort1_s_axil_regs #(.NUM_REGS(2)) dut_n2 (
        .ACLK(clk), .ARESETN(aresetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready2), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready2), .S_AXI_BRESP(bresp2),
        .S_AXI_BVALID(bvalid2), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready2),
        .S_AXI_RDATA(rdata2), .S_AXI_RRESP(rresp2), .S_AXI_RVALID(rvalid2),
        .S_AXI_RREADY(rready), .reg_q(regq2), .wr_pulse(wr_pulse2)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] s);
        b_exp_t e;
        int idx = int'(addr[3:2]);
        m1[idx] = merge(m1[idx], d, s);
        e.resp  = RESP_OKAY;
        e.pulse = 4'b0001 << idx;
        if (idx < 2) begin
            m2[idx]  = merge(m2[idx], d, s);
            e.resp2  = RESP_OKAY;
            e.pulse2 = 2'b01 << idx;
        end else begin
            e.resp2  = RESP_SLVERR;
            e.pulse2 = 2'b00;
        end
        b_q.push_back(e);
    endtask

    task automatic model_read(input logic [3:0] addr);
        r_exp_t e;
        int idx = int'(addr[3:2]);
        e.data = m1[idx];
        e.resp = RESP_OKAY;
        if (idx < 2) begin
            e.data2 = m2[idx];
            e.resp2 = RESP_OKAY;
        end else begin
            e.data2 = 32'h0;
            e.resp2 = RESP_SLVERR;
        end
        r_q.push_back(e);
    endtask

    task automatic wait_b(input int hold, input int exp_lat);
        b_exp_t e = b_q.pop_front();
        int n = 0;
        bready = 1'b0;
        while (!bvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (n != exp_lat) begin
            tests_failed++;
            $display("FAIL b_latency: got %0d cycles, expected %0d", n, exp_lat);
        end
        if (!bvalid) return;
        tests_run++;
        if ({bresp, bresp2, wr_pulse, wr_pulse2} !== {e.resp, e.resp2, e.pulse, e.pulse2}) begin
            tests_failed++;
            $display("FAIL b_resp: got bresp=%h/%h pulse=%b/%b, expected %h/%h %b/%b",
                     bresp, bresp2, wr_pulse, wr_pulse2, e.resp, e.resp2, e.pulse, e.pulse2);
        end
        tests_run++;
        if ({regq, regq2} !== {m1[3], m1[2], m1[1], m1[0], m2[1], m2[0]}) begin
            tests_failed++;
            $display("FAIL reg_q: got %h / %h, expected %h / %h", regq, regq2,
                     {m1[3], m1[2], m1[1], m1[0]}, {m2[1], m2[0]});
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({bvalid, bresp, awready, wready, wr_pulse} !== {1'b1, e.resp, 2'b00, 4'b0000}) begin
                tests_failed++;
                $display("FAIL b_hold: got bvalid=%b bresp=%h awr=%b wr=%b pulse=%b, expected 1 %h 0 0 0000",
                         bvalid, bresp, awready, wready, wr_pulse, e.resp);
            end
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        tests_run++;
        if ({bvalid, wr_pulse, wr_pulse2} !== 7'b0) begin
            tests_failed++;
            $display("FAIL b_done: got bvalid=%b pulse=%b/%b, expected all 0",
                     bvalid, wr_pulse, wr_pulse2);
        end
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] s,
                            input int w_lead, input int hold);
        int cyc = 0;
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        model_write(addr, d, s);
        awaddr = addr; wdata = d; wstrb = s;
        wvalid = 1'b1;
        awvalid = (w_lead == 0);
        while (!(aw_done && w_done) && cyc < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            cyc++;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid = 1'b0;  w_done = 1;  end
            if (!aw_done && !awvalid && cyc >= w_lead) awvalid = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        tests_run++;
        if (!(aw_done && w_done)) begin
            tests_failed++;
            $display("FAIL aw_w_handshake: got aw=%0b w=%0b, expected both accepted", aw_done, w_done);
            void'(b_q.pop_front());
            return;
        end
        wait_b(hold, 1);
    endtask

    task automatic check_r();
        r_exp_t e = r_q.pop_front();
        tests_run++;
        if ({rvalid, rdata, rresp, rvalid2, rdata2, rresp2} !==
            {1'b1, e.data, e.resp, 1'b1, e.data2, e.resp2}) begin
            tests_failed++;
            $display("FAIL r_data: got %b %h %h / %b %h %h, expected 1 %h %h / 1 %h %h",
                     rvalid, rdata, rresp, rvalid2, rdata2, rresp2, e.data, e.resp, e.data2, e.resp2);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({rvalid, rdata, rresp, arready} !== {1'b1, e.data, e.resp, 1'b0}) begin
            tests_failed++;
            $display("FAIL r_hold: got %b %h %h arready=%b, expected 1 %h %h 0",
                     rvalid, rdata, rresp, arready, e.data, e.resp);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        tests_run++;
        if ({rvalid, rvalid2, arready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL r_done: got rvalid=%b/%b arready=%b, expected 0/0 1",
                     rvalid, rvalid2, arready);
        end
    endtask

    task automatic do_read(input logic [3:0] addr);
        int cyc = 0;
        bit hs = 0;
        model_read(addr);
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        while (!hs && cyc < 50) begin
            hs = arvalid && arready;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 1'b0;
        tests_run++;
        if (!hs) begin
            tests_failed++;
            $display("FAIL ar_handshake: got no AR accept in %0d cycles, expected accept", cyc);
            void'(r_q.pop_front());
            return;
        end
        check_r();
    endtask

    task automatic check_ready_release();
        @(posedge clk); #1;
        tests_run++;
        if ({awready, wready, arready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL ready_edge1: got %b, expected 000", {awready, wready, arready});
        end
        @(posedge clk); #1;
        tests_run++;
        if ({awready, wready, arready} !== 3'b111) begin
            tests_failed++;
            $display("FAIL ready_edge2: got %b, expected 111", {awready, wready, arready});
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        for (int i = 0; i < 4; i++) begin m1[i] = '0; end
        m2[0] = '0; m2[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, regq, wr_pulse} !== '0)
        begin
            tests_failed++;
            $display("FAIL reset_state: got rdy=%b bv=%b rv=%b bresp=%h rresp=%h rdata=%h regq=%h pulse=%b, expected all 0",
                     {awready, wready, arready}, bvalid, rvalid, bresp, rresp, rdata, regq, wr_pulse);
        end
        aresetn = 1'b1;
        check_ready_release();
    endtask

    task automatic test_seq_write_read();
        logic [3:0] offs [4];
        offs[0] = REG0_OFF; offs[1] = REG1_OFF; offs[2] = REG2_OFF; offs[3] = REG3_OFF;
        for (int i = 0; i < 4; i++) do_write(offs[i], 32'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) do_read(offs[i]);
    endtask

    task automatic test_w_before_aw();
        do_write(REG2_OFF, 32'hA5A5_0000, 4'b1100, 3, 0);
        do_read(REG2_OFF);
    endtask

    task automatic test_backpressure();
        do_write(REG0_OFF, 32'h0000_0011, 4'hF, 0, 5);
        do_write(REG0_OFF, 32'h1234_5678, 4'b0101, 0, 0);
        do_write(REG3_OFF, 32'hFFFF_FFFF, 4'b0000, 0, 2);
    endtask

    task automatic test_same_edge();
        tests_run++;
        if ({awready, wready, arready} !== 3'b111) begin
            tests_failed++;
            $display("FAIL idle_before_same_edge: got %b, expected 111", {awready, wready, arready});
        end
        model_read(REG1_OFF);
        model_write(REG1_OFF, 32'h55, 4'hF);
        awaddr = REG1_OFF; wdata = 32'h55; wstrb = 4'hF; araddr = REG1_OFF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_b(0, 0);
        check_r();
        do_read(REG1_OFF);
    endtask

    task automatic test_out_of_range();
        do_write(REG3_OFF, 32'h0000_0077, 4'hF, 0, 0);
        do_read(REG3_OFF);
        do_write(REG0_OFF, 32'hCAFE_F00D, 4'hF, 0, 0);
        do_read(REG0_OFF);
        do_read(4'hD);
    endtask

    task automatic test_reset_inflight();
        awaddr = REG0_OFF; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (bvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL inflight_bvalid: got %b, expected 1", bvalid);
        end
        #2 aresetn = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin m1[i] = '0; end
        m2[0] = '0; m2[1] = '0;
        tests_run++;
        if ({bvalid, bvalid2, awready, wready, arready, regq, regq2, wr_pulse} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got bv=%b/%b rdy=%b regq=%h/%h pulse=%b, expected all 0",
                     bvalid, bvalid2, {awready, wready, arready}, regq, regq2, wr_pulse);
        end
        @(posedge clk); #1;
        aresetn = 1'b1;
        check_ready_release();
        do_read(REG0_OFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        awaddr = '0; araddr = '0; awprot = 3'b010; arprot = 3'b101;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = '0; wstrb = '0;
        test_reset();
        test_seq_write_read();
        test_w_before_aw();
        test_backpressure();
        test_same_edge();
        test_out_of_range();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
